// File: rtl/divider_check_multiplier.sv
// Pipelined inverse of the restoring divider: rebuilds quotient*divisor+remainder
// with one shift-and-add stage per quotient bit, flagging remainder range and overflow.
module divider_check_multiplier #(
   parameter int unsigned DIVIDENDLEN = 16,
   parameter int unsigned DIVISORLEN  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DIVIDENDLEN-1:0] quotient,
   input  logic [DIVISORLEN-1:0]  divisor,
   input  logic [DIVISORLEN-1:0]  remainder,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DIVIDENDLEN-1:0] dividend,
   output logic                   overflow,
   output logic                   rem_err
);

   localparam int unsigned DATAPATHLEN = DIVIDENDLEN + DIVISORLEN;
   localparam int unsigned LAST        = DIVIDENDLEN - 1;

   typedef struct packed {
      logic                   valid;
      logic [DATAPATHLEN-1:0] acc;
      logic [DIVIDENDLEN-1:0] qbits;
      logic [DIVISORLEN-1:0]  divisor;
      logic                   rem_err;
   } stage_t;

   stage_t stage_q [DIVIDENDLEN];
   stage_t stage_d [DIVIDENDLEN];
   logic   adv;

   // The whole pipe moves together, bubbles included, unless the output is held.
   assign adv      = !stage_q[LAST].valid | out_ready;
   assign in_ready = adv;

   always_comb begin
      stage_d = stage_q;
      if (adv) begin
         stage_d[0].valid   = in_valid;
         stage_d[0].acc     = DATAPATHLEN'(remainder)
                            + (quotient[0] ? DATAPATHLEN'(divisor) : DATAPATHLEN'(0));
         stage_d[0].qbits   = quotient >> 1;
         stage_d[0].divisor = divisor;
         stage_d[0].rem_err = (remainder >= divisor);
         // qbits is shifted right each stage, so bit 0 is always quotient[k] at stage k.
         for (int k = 1; k < int'(DIVIDENDLEN); k++) begin
            stage_d[k].valid   = stage_q[k-1].valid;
            stage_d[k].acc     = stage_q[k-1].acc
                               + (stage_q[k-1].qbits[0]
                                  ? (DATAPATHLEN'(stage_q[k-1].divisor) << k)
                                  : DATAPATHLEN'(0));
            stage_d[k].qbits   = stage_q[k-1].qbits >> 1;
            stage_d[k].divisor = stage_q[k-1].divisor;
            stage_d[k].rem_err = stage_q[k-1].rem_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DIVIDENDLEN); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign out_valid = stage_q[LAST].valid;
   assign dividend  = stage_q[LAST].acc[DIVIDENDLEN-1:0];
   assign overflow  = |stage_q[LAST].acc[DATAPATHLEN-1:DIVIDENDLEN];
   assign rem_err   = stage_q[LAST].rem_err;

endmodule

// File: tb/tb_divider_check_multiplier.sv
// Bench for divider_check_multiplier: table vectors, random stream, stall and
// mid-stream reset, all checked through an in-order expected-result queue.
module tb_divider_check_multiplier;

   localparam int unsigned DL = 16;
   localparam int unsigned VL = 8;
   localparam int unsigned DP = DL + VL;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DL-1:0] quotient;
   logic [VL-1:0] divisor;
   logic [VL-1:0] remainder;
   logic          out_valid;
   logic          out_ready;
   logic [DL-1:0] dividend;
   logic          overflow;
   logic          rem_err;

   divider_check_multiplier #(.DIVIDENDLEN(DL), .DIVISORLEN(VL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .quotient  (quotient),
      .divisor   (divisor),
      .remainder (remainder),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dividend  (dividend),
      .overflow  (overflow),
      .rem_err   (rem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [DL-1:0] dv;
      logic          ovf;
      logic          rem;
   } exp_t;

   typedef struct {
      logic [DL-1:0] q;
      logic [VL-1:0] d;
      logic [VL-1:0] r;
      exp_t          e;
   } vec_t;

   exp_t exp_q[$];
   exp_t cur_exp;
   exp_t mon_e;
   int   checks  = 0;
   int   errors  = 0;
   int   pops    = 0;
   int   run_len = 0;
   int   max_run = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [DL-1:0] q, input logic [VL-1:0] d,
                                  input logic [VL-1:0] r);
      logic [DP-1:0] f;
      exp_t          e;
      f     = DP'(q) * DP'(d) + DP'(r);
      e.dv  = f[DL-1:0];
      e.ovf = |f[DP-1:DL];
      e.rem = (r >= d);
      return e;
   endfunction

   // Scoreboard: push on acceptance, pop and compare on consumption.
   always @(negedge clk) begin
      if (!rst_n) begin
         run_len = 0;
      end else begin
         if (out_valid && out_ready) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual=0x%0h required=none", dividend);
            end else begin
               mon_e = exp_q.pop_front();
               pops++;
               check("dividend", 32'(dividend), 32'(mon_e.dv));
               check("overflow", 32'(overflow), 32'(mon_e.ovf));
               check("rem_err",  32'(rem_err),  32'(mon_e.rem));
            end
         end else begin
            run_len = 0;
         end
         if (in_valid && in_ready) exp_q.push_back(cur_exp);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [DL-1:0] q, input logic [VL-1:0] d,
                       input logic [VL-1:0] r, input exp_t e);
      bit done;
      quotient  = q;
      divisor   = d;
      remainder = r;
      cur_exp   = e;
      in_valid  = 1'b1;
      done      = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=in_ready_low required=accept");
      end
   endtask

   task automatic send_rand();
      logic [DL-1:0] q;
      logic [VL-1:0] d;
      logic [VL-1:0] r;
      q = DL'($urandom);
      d = VL'($urandom);
      r = VL'($urandom);
      if ($urandom_range(0, 7) == 0) d = '0;
      send(q, d, r, model(q, d, r));
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick(1);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   vec_t vecs[7];
   int   lat;
   int   p0;
   bit   found;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'h00FF, 8'hFF, 8'hFE, '{16'hFEFF, 1'b0, 1'b0}};
      vecs[1] = '{16'hFFFF, 8'hFF, 8'hFE, '{16'hFFFF, 1'b1, 1'b0}};
      vecs[2] = '{16'h1234, 8'h00, 8'h00, '{16'h0000, 1'b0, 1'b1}};
      vecs[3] = '{16'h0003, 8'h05, 8'h07, '{16'h0016, 1'b0, 1'b1}};
      vecs[4] = '{16'hFFFF, 8'hFF, 8'hFF, '{16'h0000, 1'b1, 1'b1}};
      vecs[5] = '{16'h0101, 8'h01, 8'h00, '{16'h0101, 1'b0, 1'b0}};
      vecs[6] = '{16'h0000, 8'h80, 8'h7F, '{16'h007F, 1'b0, 1'b0}};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      quotient  = '0;
      divisor   = '0;
      remainder = '0;
      cur_exp   = '0;
      tick(2);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_dividend",  32'(dividend),  32'd0);
      check("reset_overflow",  32'(overflow),  32'd0);
      check("reset_rem_err",   32'(rem_err),   32'd0);
      check("reset_in_ready",  32'(in_ready),  32'd1);
      rst_n = 1'b1;
      tick(1);

      // Latency of a lone item through an empty pipe.
      send(vecs[0].q, vecs[0].d, vecs[0].r, vecs[0].e);
      idle();
      lat   = 0;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         if (out_valid) found = 1'b1;
         else begin
            tick(1);
            lat++;
         end
      end
      check("latency", 32'(lat), 32'(DL - 1));
      drain("drain_latency");

      for (int i = 0; i < 7; i++) send(vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].e);
      idle();
      drain("drain_table");

      max_run = 0;
      p0      = pops;
      for (int i = 0; i < 40; i++) send_rand();
      idle();
      drain("drain_stream");
      check("stream_count", 32'(pops - p0), 32'd40);
      check("stream_run",   32'(max_run),   32'd40);

      // Fill with out_ready low, then hold a stall for 5 cycles.
      out_ready = 1'b0;
      p0        = pops;
      send(vecs[1].q, vecs[1].d, vecs[1].r, vecs[1].e);
      for (int i = 1; i < int'(DL); i++) send_rand();
      quotient  = 16'h0042;
      divisor   = 8'h11;
      remainder = 8'h03;
      cur_exp   = model(16'h0042, 8'h11, 8'h03);
      for (int c = 0; c < 5; c++) begin
         check("stall_in_ready",  32'(in_ready),  32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_dividend",  32'(dividend),  32'(vecs[1].e.dv));
         check("stall_overflow",  32'(overflow),  32'(vecs[1].e.ovf));
         tick(1);
      end
      out_ready = 1'b1;
      send(16'h0042, 8'h11, 8'h03, model(16'h0042, 8'h11, 8'h03));
      idle();
      drain("drain_stall");
      check("stall_count", 32'(pops - p0), 32'(DL + 1));

      // Eight items in flight, head stalled at the output, then async reset.
      for (int i = 0; i < 8; i++) send_rand();
      idle();
      out_ready = 1'b0;
      tick(12);
      check("pre_reset_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("async_reset_out_valid", 32'(out_valid), 32'd0);
      check("async_reset_dividend",  32'(dividend),  32'd0);
      check("async_reset_rem_err",   32'(rem_err),   32'd0);
      check("async_reset_in_ready",  32'(in_ready),  32'd1);
      tick(2);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      p0        = pops;
      for (int i = 2; i < 5; i++) send(vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].e);
      idle();
      drain("drain_after_reset");
      tick(20);
      check("after_reset_count", 32'(pops - p0), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/divider_check_multiplier.md
Name: divider_check_multiplier

Overview:
- Pipelined inverse of the restoring divider. Rebuilds the dividend as quotient*divisor + remainder.
- Uses one shift-and-add stage per quotient bit, the mirror image of the divider's one subtract stage per bit.
- Sits beside the pipelined divider as its inverse datapath, for self-check and for round-trip tests.
- Also reports a remainder-range error and dividend overflow.

Parameters:
- DIVIDENDLEN, 16: width of the reconstructed dividend and of the quotient input. This is also the pipeline depth.
- DIVISORLEN, 8: width of the divisor and remainder inputs.
- DATAPATHLEN, DIVIDENDLEN+DIVISORLEN (localparam): width of the internal accumulator.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  an input operand set is present.
- in_ready  output  1  the block accepts an input this cycle.
- quotient  input  DIVIDENDLEN  quotient operand.
- divisor  input  DIVISORLEN  divisor operand.
- remainder  input  DIVISORLEN  remainder operand.
- out_valid  output  1  a result is present.
- out_ready  input  1  the consumer accepts the result this cycle.
- dividend  output  DIVIDENDLEN  low DIVIDENDLEN bits of quotient*divisor+remainder.
- overflow  output  1  the full result does not fit in DIVIDENDLEN bits.
- rem_err  output  1  remainder >= divisor, which includes divisor == 0.

Behaviour:
- Reset: clk single clock; rst_n asynchronous, active-low.
  - While rst_n=0: all stage valid bits, out_valid, dividend, overflow and rem_err are 0.
  - in_ready=1 during and after reset.
- Reset mid-operation discards all in-flight items. No partial result is emitted after reset.
- Pipeline: DIVIDENDLEN register stages, S0..S(DIVIDENDLEN-1).
  - Each stage holds: valid, accumulator (DATAPATHLEN), the unconsumed quotient bits, divisor, and rem_err.
- Stage S0 loads on acceptance:
  - acc = zero-extended remainder + (quotient[0] ? divisor : 0).
  - rem_err = (remainder >= divisor), as an unsigned compare.
- Stage Sk (k>=1) loads from S(k-1): acc += quotient[k] ? (divisor << k) : 0.
  - Divisor is zero-extended to DATAPATHLEN before shifting.
  - Additions are unsigned and never truncate; the maximum value fits in DATAPATHLEN.
- Outputs come from S(DIVIDENDLEN-1):
  - dividend = acc[DIVIDENDLEN-1:0].
  - overflow = |acc[DATAPATHLEN-1:DIVIDENDLEN].
  - out_valid is that stage's valid bit.
- Advance rule: adv = !out_valid | out_ready.
  - When adv=1, every stage loads from its predecessor and S0 loads from the input. Bubbles, meaning invalid stages, also shift.
  - When adv=0, every stage holds its contents. Outputs stay stable while out_valid=1 and out_ready=0.
- in_ready = adv, combinational. An input is accepted when in_valid & in_ready; if in_valid=0 while adv=1, S0 loads a bubble.
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+DIVIDENDLEN-1, assuming no stalls. Each stall cycle adds exactly one cycle.
- Throughput: one result per cycle while out_ready stays 1.
- Simultaneous events: with a full pipeline, out_ready=1 and in_valid=1 in the same cycle, the output is consumed and the input accepted on the same edge. No loss, no duplication.
- Ordering: results leave in acceptance order. Valid count in flight never exceeds DIVIDENDLEN.
- Operand values on ports are don't-care when their valid is 0. dividend, overflow and rem_err are don't-care when out_valid=0, except after reset, when they are 0.

Test Plan:
- Reset, then present q=0x00FF, d=0xFF, r=0xFE with out_ready=1.
  - Required: out_valid exactly DIVIDENDLEN-1 cycles after acceptance; dividend=0xFEFF, overflow=0, rem_err=0.
- Present q=0xFFFF, d=0xFF, r=0xFE.
  - Required: dividend=0xFFFF (full value 0xFEFFFF), overflow=1, rem_err=0.
- Present q=0x1234, d=0x00, r=0x00, then q=0x0003, d=0x05, r=0x07.
  - Required first result: dividend=0x0000, rem_err=1, overflow=0.
  - Required second result: dividend=0x0016, rem_err=1.
- Stream 40 back-to-back random operands with out_ready=1.
  - Required: one result per cycle, in order, each matching the q*d+r reference model.
- Fill the pipeline, then hold out_ready=0 for 5 cycles.
  - Required: in_ready=0 throughout; outputs stable; after release, all results arrive in order with none dropped or duplicated.
- Drive rst_n low asynchronously mid-stream with 8 items in flight.
  - Required: out_valid=0 immediately; after release, only items accepted afterwards emerge, with correct values.
